// File: rtl/muldiv_seq_pkg.sv
// Shared ALU operation codes, widths and sequencer state encoding for the
// HI/LO multiply/divide sequencer.
package muldiv_seq_pkg;

    localparam int ALUOP_BITS = 6;
    localparam int WORD_W     = 32;
    localparam int DWORD_W    = 64;

    typedef logic [ALUOP_BITS-1:0] aluop_t;
    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [DWORD_W-1:0]    dword_t;

    localparam aluop_t ALU_NOP   = 6'h00;
    localparam aluop_t ALU_MULT  = 6'h18;
    localparam aluop_t ALU_MULTU = 6'h19;
    localparam aluop_t ALU_DIV   = 6'h1a;
    localparam aluop_t ALU_DIVU  = 6'h1b;
    localparam aluop_t ALU_MUL   = 6'h1c;
    localparam aluop_t ALU_MADD  = 6'h20;
    localparam aluop_t ALU_MADDU = 6'h21;
    localparam aluop_t ALU_MSUB  = 6'h22;
    localparam aluop_t ALU_MSUBU = 6'h23;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_ACC  = 3'd2;
    localparam logic [2:0] ST_DIV  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef struct packed {
        logic neg_quot;
        logic neg_rem;
    } div_sign_t;

    function automatic logic is_mul_op(input aluop_t op);
        case (op)
            ALU_MULT, ALU_MULTU, ALU_MUL,
            ALU_MADD, ALU_MADDU, ALU_MSUB, ALU_MSUBU: is_mul_op = 1'b1;
            default:                                 is_mul_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input aluop_t op);
        case (op)
            ALU_DIV, ALU_DIVU: is_div_op = 1'b1;
            default:           is_div_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_acc_op(input aluop_t op);
        case (op)
            ALU_MADD, ALU_MADDU, ALU_MSUB, ALU_MSUBU: is_acc_op = 1'b1;
            default:                                 is_acc_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_sub_op(input aluop_t op);
        case (op)
            ALU_MSUB, ALU_MSUBU: is_sub_op = 1'b1;
            default:             is_sub_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_gpr_op(input aluop_t op);
        case (op)
            ALU_MUL: is_gpr_op = 1'b1;
            default: is_gpr_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_op(input aluop_t op);
        case (op)
            ALU_MULT, ALU_MUL, ALU_MADD, ALU_MSUB, ALU_DIV: is_signed_op = 1'b1;
            default:                                       is_signed_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_seq_mul_pipe.sv
// 33x33 signed multiplier with a configurable number of register stages and
// a matching valid chain; flush empties the pipe.
module muldiv_seq_mul_pipe
    import muldiv_seq_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic        out_valid,
    output dword_t      prod
);

    dword_t              a_ext_s;
    dword_t              b_ext_s;
    dword_t              prod_s;
    dword_t              stage_r [STAGES];
    logic [STAGES-1:0]   valid_r;

    // sign-extending to 64 bits keeps the product exact modulo 2^64
    assign a_ext_s = {{31{a[32]}}, a};
    assign b_ext_s = {{31{b[32]}}, b};
    assign prod_s  = a_ext_s * b_ext_s;

    // product register chain and its valid bits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_r <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= 64'd0;
            end
        end else if (flush) begin
            valid_r <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= 64'd0;
            end
        end else begin
            valid_r[0] <= in_valid;
            stage_r[0] <= prod_s;
            for (int i = 1; i < STAGES; i++) begin
                valid_r[i] <= valid_r[i-1];
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[STAGES-1];
    assign prod      = stage_r[STAGES-1];

endmodule

// File: rtl/muldiv_seq.sv
// EX-stage multi-cycle sequencer for MIPS32 HI/LO multiply, multiply-accumulate
// and divide; stalls the pipeline and emits one HI/LO write per operation.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int MUL_STAGES = 2,
    parameter int ALUOP_W    = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [31:0]        opr1,
    input  logic [31:0]        opr2,
    input  logic [63:0]        hilo_i,
    input  logic               flush,
    output logic               stall_o,
    output logic               done,
    output logic               whilo,
    output logic [63:0]        hilo_o,
    output logic [31:0]        mul_res
);

    logic [2:0]         state_r;
    logic [2:0]         state_nxt_s;
    logic [ALUOP_W-1:0] op_r;
    dword_t             hilo_r;
    dword_t             prod_r;
    dword_t             acc_s;

    logic               supported_s;
    logic               accept_s;
    logic               sign_s;
    logic               div_zero_s;

    logic               pipe_in_valid_s;
    logic [32:0]        pipe_a_s;
    logic [32:0]        pipe_b_s;
    logic               pipe_valid_s;
    dword_t             pipe_prod_s;

    word_t              abs1_s;
    word_t              abs2_s;
    logic [5:0]         div_cnt_r;
    word_t              rem_r;
    word_t              quot_r;
    word_t              dvsr_r;
    div_sign_t          div_sign_r;
    logic [32:0]        div_shift_s;
    logic [32:0]        div_diff_s;
    logic               div_ge_s;
    word_t              quot_fix_s;
    word_t              rem_fix_s;

    logic               done_r;
    logic               whilo_r;
    dword_t             hilo_out_r;
    word_t              mul_res_r;

    assign supported_s = is_mul_op(aluop) | is_div_op(aluop);
    assign accept_s    = (state_r == ST_IDLE) & start & supported_s & ~flush;
    assign stall_o     = start & supported_s & (state_r != ST_DONE) & ~flush;
    assign sign_s      = is_signed_op(aluop);
    assign div_zero_s  = (opr2 == 32'd0);

    // operands come straight from the held EX inputs so stage 1 fills on the accept edge
    assign pipe_a_s        = {sign_s & opr1[31], opr1};
    assign pipe_b_s        = {sign_s & opr2[31], opr2};
    assign pipe_in_valid_s = accept_s & is_mul_op(aluop);

    muldiv_seq_mul_pipe #(
        .STAGES (MUL_STAGES)
    ) u_mul_pipe (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (pipe_in_valid_s),
        .a         (pipe_a_s),
        .b         (pipe_b_s),
        .out_valid (pipe_valid_s),
        .prod      (pipe_prod_s)
    );

    assign abs1_s = (sign_s & opr1[31]) ? (32'd0 - opr1) : opr1;
    assign abs2_s = (sign_s & opr2[31]) ? (32'd0 - opr2) : opr2;
    assign acc_s  = is_sub_op(op_r) ? (hilo_r - prod_r) : (hilo_r + prod_r);

    // restoring divide step and final sign correction
    always_comb begin
        div_shift_s = {rem_r, quot_r[31]};
        div_diff_s  = div_shift_s - {1'b0, dvsr_r};
        div_ge_s    = ~div_diff_s[32];
        if (div_sign_r.neg_quot) begin
            quot_fix_s = 32'd0 - quot_r;
        end else begin
            quot_fix_s = quot_r;
        end
        if (div_sign_r.neg_rem) begin
            rem_fix_s = 32'd0 - rem_r;
        end else begin
            rem_fix_s = rem_r;
        end
    end

    // next-state selection
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!accept_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (is_mul_op(aluop)) begin
                        state_nxt_s = ST_MUL;
                    end else if (div_zero_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DIV;
                    end
                end
                ST_MUL: begin
                    if (!pipe_valid_s) begin
                        state_nxt_s = ST_MUL;
                    end else if (is_acc_op(op_r)) begin
                        state_nxt_s = ST_ACC;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                ST_ACC:  state_nxt_s = ST_DONE;
                ST_DIV: begin
                    if (div_cnt_r == 6'd32) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DIV;
                    end
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // operation context captured at accept, product held for the accumulate cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_r   <= '0;
            hilo_r <= 64'd0;
            prod_r <= 64'd0;
        end else if (accept_s) begin
            op_r   <= aluop;
            hilo_r <= hilo_i;
        end else if ((state_r == ST_MUL) && pipe_valid_s) begin
            prod_r <= pipe_prod_s;
        end
    end

    // divider: magnitudes loaded at accept, 32 iterations, then count parks at 32
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt_r  <= 6'd0;
            rem_r      <= 32'd0;
            quot_r     <= 32'd0;
            dvsr_r     <= 32'd0;
            div_sign_r <= '0;
        end else if (flush) begin
            div_cnt_r  <= 6'd0;
            rem_r      <= 32'd0;
            quot_r     <= 32'd0;
            dvsr_r     <= 32'd0;
            div_sign_r <= '0;
        end else if (accept_s && is_div_op(aluop)) begin
            div_cnt_r           <= 6'd0;
            rem_r               <= 32'd0;
            quot_r              <= abs1_s;
            dvsr_r              <= abs2_s;
            div_sign_r.neg_quot <= sign_s & (opr1[31] ^ opr2[31]);
            div_sign_r.neg_rem  <= sign_s & opr1[31];
        end else if ((state_r == ST_DIV) && (div_cnt_r != 6'd32)) begin
            div_cnt_r <= div_cnt_r + 6'd1;
            if (div_ge_s) begin
                rem_r  <= div_diff_s[31:0];
                quot_r <= {quot_r[30:0], 1'b1};
            end else begin
                rem_r  <= div_shift_s[31:0];
                quot_r <= {quot_r[30:0], 1'b0};
            end
        end
    end

    // result registers, loaded on the edge that enters DONE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done_r     <= 1'b0;
            whilo_r    <= 1'b0;
            hilo_out_r <= 64'd0;
            mul_res_r  <= 32'd0;
        end else begin
            done_r  <= 1'b0;
            whilo_r <= 1'b0;
            if (!flush) begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s && is_div_op(aluop) && div_zero_s) begin
                            hilo_out_r <= {opr1, 32'hffff_ffff};
                            done_r     <= 1'b1;
                            whilo_r    <= 1'b1;
                        end
                    end
                    ST_MUL: begin
                        if (pipe_valid_s && !is_acc_op(op_r)) begin
                            done_r <= 1'b1;
                            if (is_gpr_op(op_r)) begin
                                mul_res_r <= pipe_prod_s[31:0];
                            end else begin
                                hilo_out_r <= pipe_prod_s;
                                whilo_r    <= 1'b1;
                            end
                        end
                    end
                    ST_ACC: begin
                        hilo_out_r <= acc_s;
                        done_r     <= 1'b1;
                        whilo_r    <= 1'b1;
                    end
                    ST_DIV: begin
                        if (div_cnt_r == 6'd32) begin
                            hilo_out_r <= {rem_fix_s, quot_fix_s};
                            done_r     <= 1'b1;
                            whilo_r    <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // a flush in the DONE cycle must still kill the write
    assign done    = done_r & ~flush;
    assign whilo   = whilo_r & ~flush;
    assign hilo_o  = hilo_out_r;
    assign mul_res = mul_res_r;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for MIPS32 HI/LO instructions: MULT, MULTU, MUL, MADD, MADDU, MSUB, MSUBU, DIV and DIVU.
- Sits in the EX stage beside the ALU and owns a pipelined multiplier core and an iterative radix-2 divider.
- Holds the pipeline with a stall until the result is ready, then emits one HI/LO write (and the MUL GPR result).
- MTHI/MTLO stay in the existing single-cycle EX result path and never enter this block.

Parameters:
- MUL_STAGES, 2, register stages in the multiplier core (1..4).
- ALUOP_W, 6, width of the ALU operation code (matches the shared ALUOp bus).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  EX holds a mul/div op; held high with stable operands until done.
- aluop  in  ALUOP_W  operation code (shared ALU_* constants).
- opr1  in  32  rs operand.
- opr2  in  32  rt operand.
- hilo_i  in  64  current HI:LO, already forwarded; sampled at accept.
- flush  in  1  exception/branch flush; aborts the operation.
- stall_o  out  1  request to freeze IF..EX.
- done  out  1  one-cycle result-valid pulse.
- whilo  out  1  HI/LO write enable, aligned with done.
- hilo_o  out  64  new {HI,LO}.
- mul_res  out  32  low word for MUL's GPR write, valid with done.

Behaviour:
- Reset (async, resetn low): state=IDLE; done, whilo, stall_o=0; hilo_o, mul_res=0; counters and divider registers cleared.
- Accept: in IDLE with start=1, flush=0 and a supported aluop.
  - Latch aluop, opr1, opr2 and hilo_i.
  - Non-mul/div aluop: ignored, stall_o stays 0.
- stall_o = start & supported op & (state != DONE) & ~flush.
  - Combinational, so the pipeline freezes in the accept cycle itself.
- States: IDLE, MUL, ACC, DIV, DONE.
  - IDLE -> MUL on a multiply op.
  - IDLE -> DIV on a divide op with opr2 != 0.
  - IDLE -> DONE on a divide op with opr2 == 0.
  - MUL counts MUL_STAGES cycles.
    - Then -> ACC for MADD/MADDU/MSUB/MSUBU.
    - Otherwise -> DONE.
  - ACC: one cycle, 64-bit add or subtract with the latched hilo_i, then -> DONE.
  - DIV: 32 iterations, one quotient bit per cycle, then one sign-fix cycle, then -> DONE.
  - DONE: done=1; whilo=1 for every op except MUL; next state IDLE.
- Latency from the accept edge to the done cycle:
  - Plain multiply: MUL_STAGES+1.
  - Multiply-accumulate: MUL_STAGES+2.
  - Divide: 34.
  - Divide by zero: 1.
- Multiply arithmetic:
  - Signed ops sign-extend to 33 bits; unsigned ops zero-extend. Product is 64 bits.
  - MADD: hilo_o = hilo_i + prod. MSUB: hilo_o = hilo_i - prod. Both mod 2^64.
  - MUL: mul_res = prod[31:0]; whilo=0 and HI/LO are untouched.
  - MULT/MULTU: hilo_o = prod.
- Divide arithmetic:
  - Work on magnitudes: |opr1| / |opr2|, unsigned for DIVU.
  - Quotient sign = sign1^sign2; remainder sign = sign1 (DIV only). hilo_o = {rem, quot}.
  - 0x80000000 / 0xFFFFFFFF (DIV): quot=0x80000000, rem=0 (wraps, no trap).
  - Divide by zero: hilo_o = {opr1, 32'hFFFFFFFF}.
- Flush:
  - In any state, flush=1 forces IDLE on the next edge.
  - Outputs that cycle: whilo=0, done=0, stall_o=0.
  - In-flight multiplier stages and divider registers are discarded; a flush in the DONE cycle also suppresses whilo.
- start dropped mid-operation without flush is illegal; the block completes the operation anyway and outputs done.
- Back-to-back ops: a new accept is allowed in the IDLE cycle right after DONE. There is no accept in the DONE cycle, so HI/LO hazards are resolved by forwarding before start.
- hilo_o and mul_res hold their last values outside DONE; only done/whilo qualify them.

Decomposition:
- Shared defines: ALU_MULT, ALU_MULTU, ALU_MUL, ALU_MADD, ALU_MADDU, ALU_MSUB, ALU_MSUBU, ALU_DIV, ALU_DIVU codes; the ALUOp, Word and DWord widths; the state encoding.
- Sub-module mul_pipe: 33x33 signed multiplier with MUL_STAGES register stages and a valid shift chain, cleared by flush.
- The divider stays inline in muldiv_seq.

Test Plan:
- MULT opr1=0xFFFFFFFE (-2), opr2=3, MUL_STAGES=2 -> done at cycle 3 after accept; whilo=1; hilo_o=0xFFFFFFFF_FFFFFFFA; stall_o high for exactly 3 cycles.
- MADDU hilo_i=0x00000000_FFFFFFFF, opr1=opr2=0x00010000 -> hilo_o=0x00000001_FFFFFFFF at cycle 4. MSUB hilo_i=0, opr1=1, opr2=1 -> hilo_o=0xFFFFFFFF_FFFFFFFF.
- DIV opr1=-7 (0xFFFFFFF9), opr2=2 -> done at cycle 34; hilo_o={0xFFFFFFFF, 0xFFFFFFFD}. DIVU 100/7 -> {2, 14}.
- DIVU opr2=0, opr1=0x1234 -> done next cycle; hilo_o={0x00001234, 0xFFFFFFFF}.
- DIV in progress, flush at iteration 10 -> IDLE next cycle; whilo never asserts; an immediately following MUL 6*7 -> mul_res=42 with whilo=0.
- resetn pulsed low mid-MUL -> all outputs 0 immediately (asynchronous); no done after release until a new start.
